mux_select_scheduler: RTL
=========================

// Module: mux_select_scheduler
// PURPOSE
//   Turns the 5 raw push-buttons and the mode switch into a registered 3-bit
//   select for the downstream output mux. Each button is debounced; press
//   events are arbitrated round-robin in MANUAL mode. In SCAN mode the select
//   auto-advances every DWELL cycles. Sits between board I/O and the mux datapath.
// PARAMETERS
//   N_SRC     5   number of buttons/mux sources (legal 2..8)
//   SEL_W     3   select width, >= clog2(N_SRC)
//   DEBOUNCE  4   consecutive identical samples needed to accept a level (>=1)
//   DWELL     16  cycles each source is held in SCAN mode (>=2)
// PORTS
//   clk         in   1      single clock, all logic rising-edge
//   reset       in   1      asynchronous, active-low; low = all state cleared
//   buttons     in   N_SRC  raw button levels, synchronous to clk
//   switch      in   1      mode: 0 = MANUAL, 1 = SCAN
//   sel         out  SEL_W  registered mux select, always < N_SRC
//   sel_valid   out  1      1 once a source has been selected since reset
//   sel_change  out  1      1-cycle pulse on the edge sel changes or valid rises
//   mode        out  2      current state: 0 IDLE, 1 MANUAL, 2 SCAN
// BEHAVIOUR
//   Reset (reset=0, async): sel=0, sel_valid=0, sel_change=0, mode=IDLE,
//     debounced levels=0, debounce counters=0, dwell counter=0, rr pointer=0.
//   Debounce per bit i: cnt_i increments while buttons[i] != deb[i], clears when
//     equal. On the DEBOUNCE-th consecutive differing sample deb[i] flips, cnt_i=0.
//     Pulses shorter than DEBOUNCE cycles have no effect. Release debounced alike.
//   Press event press[i] = deb[i] rising (registered flip). Only presses act;
//     holding or releasing a button never changes sel.
//   Latency: button level first sampled at edge k -> deb flips at edge
//     k+DEBOUNCE-1 -> sel updated at edge k+DEBOUNCE, sel_change high that cycle.
//   Arbitration (several press events same cycle): scan from (sel+1) mod N_SRC
//     upward with wrap; first pressed index wins; others dropped, not queued.
//   FSM:
//     IDLE:   switch=1 -> SCAN (sel=0, valid=1, dwell=0, sel_change pulse).
//             press & switch=0 -> MANUAL, sel=winner, valid=1.
//     MANUAL: press -> sel=winner (pulse only if value differs).
//             switch=1 -> SCAN, dwell restarts at 0, sel unchanged.
//     SCAN:   dwell counts 0..DWELL-1; at DWELL-1 sel=(sel+1) mod N_SRC
//             (N_SRC-1 wraps to 0), dwell=0. press -> sel=winner, dwell=0.
//             switch=0 -> MANUAL, sel held, dwell cleared.
//   Simultaneous: switch change and press same edge -> mode transition taken
//     and sel=winner in same edge; press wins over dwell-expiry advance.
//   sel_change: high exactly one cycle after any edge where sel value changed
//     or sel_valid 0->1; never asserted otherwise.
//   sel never leaves 0..N_SRC-1; no state reachable other than IDLE/MANUAL/SCAN.
//   Reset mid-operation: immediate return to reset values; in-progress
//     debounce counts discarded; bench must see sel=0, mode=IDLE while reset=0.
// TESTING (DEBOUNCE=4, DWELL=16, N_SRC=5)
//   T1 reset, buttons=5'b00100 held 6 cycles -> sel=2 exactly 4 edges after first
//      sample, sel_valid=1, sel_change one 1-cycle pulse, mode=MANUAL.
//   T2 buttons=5'b00001 for 3 cycles then 0 -> no change (glitch rejected);
//      5'b10111 pressed together with sel=2 -> sel=4 (rr from 3), then sel=0 on next
//      all-new press set 5'b00011 from sel=4.
//   T3 switch=1 in MANUAL sel=1 -> sel 1->2->3->4->0 every 16 cycles, 4->0 wrap,
//      one sel_change per step, mode=SCAN.
//   T4 SCAN, press button 3 at dwell=10 -> sel=3, next advance to 4 16 cycles later;
//      press coincident with dwell expiry -> sel=pressed index, not sel+1.
//   T5 switch=0 during SCAN -> sel held, mode=MANUAL, no further advances over 100 cycles.
//   T6 reset pulsed low mid-debounce and mid-SCAN -> outputs 0/IDLE asynchronously;
//      after release a held button still needs full 4-sample debounce.

Source files
------------

// File: rtl/mux_select_scheduler.sv
// Debounced push-button / mode-switch front end producing a registered mux select.
// MANUAL mode arbitrates press events round-robin; SCAN mode auto-advances every DWELL cycles.
module mux_select_scheduler #(
    parameter int unsigned N_SRC    = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DWELL    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] buttons,
    input  logic             switch,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             sel_change,
    output logic [1:0]       mode
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned DW_W  = $clog2(DWELL);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   deb_q, deb_d;
    logic [N_SRC-1:0]   press_q, press_d;
    logic [CNT_W-1:0]   cnt_q [N_SRC];
    logic [CNT_W-1:0]   cnt_d [N_SRC];
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               change_q, change_d;
    logic [SEL_W-1:0]   win;
    logic               found;
    logic               press_any;

    // A press is registered on the same edge the debounced level rises.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cnt_d[i] = '0;
            if (buttons[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = ~deb_q[i];
                    press_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin: indices above sel first, then wrap to 0..sel.
    always_comb begin
        win       = sel_q;
        found     = 1'b0;
        press_any = |press_q;
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (!found && press_q[j] && (j > 32'(sel_q))) begin
                found = 1'b1;
                win   = SEL_W'(j);
            end
        end
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (!found && press_q[j] && (j <= 32'(sel_q))) begin
                found = 1'b1;
                win   = SEL_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (switch) begin
                    state_d = SCAN;
                    valid_d = 1'b1;
                    dwell_d = '0;
                    sel_d   = press_any ? win : '0;
                end else if (press_any) begin
                    state_d = MANUAL;
                    valid_d = 1'b1;
                    sel_d   = win;
                end
            end
            MANUAL: begin
                if (press_any) sel_d = win;
                if (switch) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                if (!switch) begin
                    state_d = MANUAL;
                    dwell_d = '0;
                    if (press_any) sel_d = win;
                end else if (press_any) begin
                    sel_d   = win;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
                dwell_d = '0;
            end
        endcase
        change_d = (sel_d != sel_q) || (valid_d && !valid_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            deb_q    <= '0;
            press_q  <= '0;
            dwell_q  <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            for (int unsigned i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            deb_q    <= deb_d;
            press_q  <= press_d;
            dwell_q  <= dwell_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            change_q <= change_d;
            for (int unsigned i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = valid_q;
    assign sel_change = change_q;
    assign mode       = state_q;

endmodule
